// File: rtl/sort_serializer.sv
// Buffers sorted triples from an upstream sorter and streams them out one word
// per cycle (no1, no2, no3), optionally dropping adjacent duplicates per triple.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        triple handshake; no1..no3 values, dedup sampled at accept
//   out_valid/out_ready      word stream; out_data, out_idx (source slot), out_last
//   count                    triples currently buffered
//   words_sent, dup_cnt      wrapping statistics counters
module sort_serializer #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         no1,
    input  logic [WIDTH-1:0]         no2,
    input  logic [WIDTH-1:0]         no3,
    input  logic                     dedup,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_idx,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNTW-1:0]          words_sent,
    output logic [CNTW-1:0]          dup_cnt
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CW   = PTRW + 1;

    logic [WIDTH-1:0] d0_q [DEPTH];
    logic [WIDTH-1:0] d1_q [DEPTH];
    logic [WIDTH-1:0] d2_q [DEPTH];
    logic [2:0]       keep_q [DEPTH];

    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNTW-1:0]  words_q, words_d;
    logic [CNTW-1:0]  dup_q, dup_d;

    logic [2:0]       head_keep;
    logic [WIDTH-1:0] head_word;
    logic             last_c;
    logic             push, xfer, pop;
    logic             keep1_c, keep2_c;
    logic [1:0]       dup_add;

    // Head entry view: selected word and whether any kept word follows it
    always_comb begin
        head_keep = keep_q[rd_ptr_q];
        head_word = d2_q[rd_ptr_q];
        last_c    = 1'b1;
        case (idx_q)
            2'd0: begin
                head_word = d0_q[rd_ptr_q];
                last_c    = ~(head_keep[1] | head_keep[2]);
            end
            2'd1: begin
                head_word = d1_q[rd_ptr_q];
                last_c    = ~head_keep[2];
            end
            default: begin
                head_word = d2_q[rd_ptr_q];
                last_c    = 1'b1;
            end
        endcase
    end

    assign in_ready   = (count_q < CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign out_data   = head_word;
    assign out_idx    = idx_q;
    assign out_last   = out_valid & last_c;
    assign count      = count_q;
    assign words_sent = words_q;
    assign dup_cnt    = dup_q;

    assign push    = in_valid & in_ready;
    assign xfer    = out_valid & out_ready;
    assign pop     = xfer & last_c;
    assign keep1_c = ~dedup | (no2 != no1);
    assign keep2_c = ~dedup | (no3 != no2);
    assign dup_add = 2'(~keep1_c) + 2'(~keep2_c);

    // Next-state for pointers, occupancy, word index and statistics
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        words_d  = words_q;
        dup_d    = dup_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
            dup_d    = dup_q + CNTW'(dup_add);
        end

        if (xfer) begin
            words_d = words_q + CNTW'(1);
            if (last_c) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
                idx_d    = 2'd0;
            end else if (idx_q == 2'd0 && head_keep[1]) begin
                idx_d = 2'd1;
            end else begin
                // slot 1 dropped, or currently at slot 1: next kept word is slot 2
                idx_d = 2'd2;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State and buffer storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            words_q  <= '0;
            dup_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d0_q[i]   <= '0;
                d1_q[i]   <= '0;
                d2_q[i]   <= '0;
                keep_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            words_q  <= words_d;
            dup_q    <= dup_d;
            if (push) begin
                d0_q[wr_ptr_q]   <= no1;
                d1_q[wr_ptr_q]   <= no2;
                d2_q[wr_ptr_q]   <= no3;
                keep_q[wr_ptr_q] <= {keep2_c, keep1_c, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_sort_serializer.sv
// Directed bench for sort_serializer with a queue-based reference model
// compared every cycle, plus hand-computed literal sequence checks.
module tb_sort_serializer;

    localparam int W    = 3;
    localparam int D    = 2;
    localparam int CNTW = 8;
    localparam int MASK = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    no1 = '0, no2 = '0, no3 = '0;
    logic            dedup = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [1:0]      out_idx;
    logic            out_last;
    logic [1:0]      count;
    logic [CNTW-1:0] words_sent;
    logic [CNTW-1:0] dup_cnt;

    sort_serializer #(.WIDTH(W), .DEPTH(D), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .no1(no1), .no2(no2), .no3(no3), .dedup(dedup),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .count(count), .words_sent(words_sent), .dup_cnt(dup_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: queue of words still to emit, triples buffered, counters
    typedef struct {
        int data;
        int idx;
        bit last;
    } word_t;

    word_t wq[$];
    int    mcount = 0;
    int    mws    = 0;
    int    mdup   = 0;
    word_t mw;
    bit    m_can_push;
    int    mv[3];
    bit    mk[3];
    int    mhi;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wq.delete();
            mcount = 0;
            mws    = 0;
            mdup   = 0;
        end else begin
            m_can_push = (mcount < D);
            if (mcount != 0 && out_ready) begin
                mw = wq.pop_front();
                mws++;
                if (mw.last) mcount--;
            end
            if (in_valid && m_can_push) begin
                mv[0] = int'(no1);
                mv[1] = int'(no2);
                mv[2] = int'(no3);
                mk[0] = 1'b1;
                mk[1] = !dedup || (mv[1] != mv[0]);
                mk[2] = !dedup || (mv[2] != mv[1]);
                mhi = 0;
                for (int i = 0; i < 3; i++) if (mk[i]) mhi = i;
                for (int i = 0; i < 3; i++) begin
                    if (mk[i]) wq.push_back('{mv[i], i, (i == mhi)});
                    else mdup++;
                end
                mcount++;
            end
        end
    end

    // Observed transfers, encoded as data*100 + idx*10 + last
    int got[$];
    int exp_seq[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", int'(out_valid), int'(mcount != 0));
            chk("in_ready", int'(in_ready), int'(mcount < D));
            chk("count", int'(count), mcount);
            chk("words_sent", int'(words_sent), mws & MASK);
            chk("dup_cnt", int'(dup_cnt), mdup & MASK);
            if (mcount != 0) begin
                chk("out_data", int'(out_data), wq[0].data);
                chk("out_idx", int'(out_idx), wq[0].idx);
                chk("out_last", int'(out_last), int'(wq[0].last));
            end
            if (out_valid && out_ready)
                got.push_back(int'(out_data) * 100 + int'(out_idx) * 10 + int'(out_last));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c, input bit d, output int iters);
        bit acc;
        in_valid = 1'b1;
        no1 = W'(a);
        no2 = W'(b);
        no3 = W'(c);
        dedup = d;
        iters = 0;
        acc = 1'b0;
        while (!acc && iters < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            iters++;
        end
        in_valid = 1'b0;
        dedup = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mcount != 0 && n < 200) begin
            step();
            n++;
        end
        if (mcount != 0) chk("drain_timeout", 0, 1);
        step();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        got.delete();
    endtask

    task automatic check_got(string name);
        chk({name, "_len"}, got.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < got.size(); i++)
            chk(name, got[i], exp_seq[i]);
        got.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int it;

    initial begin
        // Reset state
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_words", int'(words_sent), 0);
        chk("rst_dup", int'(dup_cnt), 0);
        rst = 1'b1;
        step();
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 1);

        // Single triple, no dedup
        out_ready = 1'b1;
        send(1, 4, 6, 1'b0, it);
        chk("single_lat_valid", int'(out_valid), 1);
        chk("single_lat_data", int'(out_data), 1);
        drain();
        exp_seq = '{100, 410, 621};
        check_got("single_seq");
        chk("single_words", int'(words_sent), 3);
        chk("single_idle", int'(out_valid), 0);

        // Dedup: (3,3,7) then (7,7,7)
        reset_pulse();
        out_ready = 1'b1;
        send(3, 3, 7, 1'b1, it);
        send(7, 7, 7, 1'b1, it);
        drain();
        exp_seq = '{300, 721, 701};
        check_got("dedup_seq");
        chk("dedup_dup", int'(dup_cnt), 3);
        chk("dedup_words", int'(words_sent), 3);

        // Dedup with a stall mid-triple: (2,3,3) keeps slots 0 and 1
        send(2, 3, 3, 1'b1, it);
        step();
        out_ready = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        drain();
        exp_seq = '{200, 311};
        check_got("stall_seq");

        // Backpressure
        reset_pulse();
        out_ready = 1'b0;
        send(0, 1, 2, 1'b0, it);
        send(2, 5, 5, 1'b0, it);
        chk("bp_full_ready", int'(in_ready), 0);
        chk("bp_full_count", int'(count), 2);
        in_valid = 1'b1;
        no1 = 3'd6; no2 = 3'd6; no3 = 3'd7;
        step();
        step();
        step();
        chk("bp_hold_ready", int'(in_ready), 0);
        chk("bp_hold_count", int'(count), 2);
        chk("bp_hold_data", int'(out_data), 0);
        out_ready = 1'b1;
        send(6, 6, 7, 1'b0, it);
        chk("bp_accept_edges", it, 4);
        drain();
        exp_seq = '{0, 110, 221, 200, 510, 521, 600, 610, 721};
        check_got("bp_seq");

        // Reset mid-stream while idx1 is presented
        reset_pulse();
        out_ready = 1'b1;
        send(1, 2, 3, 1'b0, it);
        step();
        chk("mid_idx", int'(out_idx), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_count", int'(count), 0);
        step();
        rst = 1'b1;
        got.delete();
        send(5, 5, 5, 1'b0, it);
        drain();
        exp_seq = '{500, 510, 521};
        check_got("post_rst_seq");

        // Pointer wrap: more than DEPTH triples back to back
        reset_pulse();
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) send(t, t + 1, t + 2, 1'b0, it);
        drain();
        exp_seq.delete();
        for (int t = 0; t < 5; t++)
            for (int i = 0; i < 3; i++)
                exp_seq.push_back((t + i) * 100 + i * 10 + ((i == 2) ? 1 : 0));
        check_got("wrap_seq");

        // Counter wrap
        reset_pulse();
        out_ready = 1'b1;
        for (int t = 0; t < 85; t++) send(1, 2, 3, 1'b0, it);
        drain();
        chk("cnt_preload", int'(words_sent), 255);
        send(7, 7, 7, 1'b1, it);
        drain();
        chk("cnt_wrap", int'(words_sent), 0);
        chk("cnt_dup", int'(dup_cnt), 2);
        got.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_serializer.md
Name: sort_serializer

Overview:
- Downstream consumer of the pipelined 3-input sorter (pplsort).
- Accepts one sorted triple {no1,no2,no3} per handshake and buffers up to DEPTH triples.
- Emits the buffered values one word per cycle on a valid/ready stream, in the order no1, no2, no3.
- Optionally drops adjacent duplicate values within a triple. Keeps word and duplicate statistics.

Parameters:
WIDTH, 3, bit width of each sorted value
DEPTH, 2, number of buffered triples; power of two, >=2
CNTW, 16, width of the statistics counters

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-low reset; 0 = reset
in_valid  input  1  upstream presents a sorted triple
in_ready  output  1  buffer can accept a triple
no1  input  WIDTH  first sorted value
no2  input  WIDTH  second sorted value
no3  input  WIDTH  third sorted value
dedup  input  1  sampled at accept; 1 = suppress words equal to the previous word of the same triple
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  current serialized word
out_idx  output  2  source slot of out_data: 0=no1, 1=no2, 2=no3
out_last  output  1  out_data is the last kept word of its triple
count  output  clog2(DEPTH)+1  triples currently buffered
words_sent  output  CNTW  total words transferred out; wraps
dup_cnt  output  CNTW  total words suppressed by dedup; wraps

Behaviour:
- Reset (rst=0, asynchronous): the following are forced regardless of clk.
  - count=0, read/write pointers=0, word index=0.
  - All buffer entries and keep-masks=0.
  - words_sent=0, dup_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=1.
  - Any buffered or partially sent triple is discarded.
- Accept: push when in_valid&in_ready.
  - in_ready = (count<DEPTH). It is a registered-state function only: no bypass, so a push is refused when full even if a pop occurs in the same cycle.
- On push, store the triple plus a 3-bit keep mask:
  - keep0=1
  - keep1 = ~dedup | (no2!=no1)
  - keep2 = ~dedup | (no3!=no2)
  - dup_cnt increments by the number of zero mask bits (0..2) in the same cycle.
- Output side:
  - out_valid = (count!=0).
  - out_data = head entry value at the current word index; out_idx = that index.
  - out_last = 1 when no keep bit above the index is set.
  - All outputs are driven from registers or muxes of registers; there is no combinational path from in_* to out_*.
- Latency: a triple accepted at edge t gives out_valid=1 after edge t, i.e. 1 cycle. Words of a triple are contiguous with no bubbles while out_ready=1.
- Transfer (out_valid&out_ready):
  - words_sent increments by 1.
  - If out_last: pop the head, increment the read pointer (mod DEPTH), reset the word index to 0.
  - Otherwise: advance the word index to the next set keep bit (may skip 1→2, or 0→2).
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Counters wrap at 2^CNTW without saturating.
- out_valid/out_data hold stable while out_ready=0.
- dedup affects only the triple it is sampled with.

Test Plan:
- Reset: hold rst=0 for 2 cycles, pulse clk -> all outputs 0, in_ready=1. Release rst -> still idle.
- Single triple (1,4,6), dedup=0, out_ready=1:
  - out_data = 1, 4, 6 on 3 consecutive cycles, starting the cycle after accept.
  - out_idx = 0, 1, 2; out_last only with 6.
  - words_sent=3, then out_valid=0.
- dedup=1, (3,3,7) then (7,7,7):
  - Outputs 3(idx0), 7(idx2, last), then 7(idx0, last).
  - dup_cnt=3, words_sent=3.
- Backpressure with out_ready=0, offering (0,1,2), (2,5,5), (6,6,7):
  - First two accepted; in_ready=0 after the second; count=2; the third is held.
  - Raise out_ready -> 0,1,2,2,5,5 then 6,6,7 with no gaps.
  - in_ready returns 1 the cycle after the first pop.
- Reset mid-stream: assert rst=0 while word idx1 is being presented -> out_valid=0 and count=0 immediately (asynchronous). After release, a new triple (5,5,5) with dedup=0 emits 5,5,5.
- Wrap: preload words_sent to 2^CNTW-1 via a long run, then transfer one word -> words_sent=0. Pointer wrap is verified by more than DEPTH consecutive triples streaming in order.
